fetch_stage: RTL and testbench

//  Instruction fetch stage feeding the decoder: issues word reads to instruction memory, buffers

---
 rtl/fetch_stage_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/fetch_stage.sv | 164 ++++++++++++++++
 tb/tb_fetch_stage.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
//   WORD_WIDTH         instruction / address width
//   BOOT_ADDR_DEFAULT  default PC loaded at reset
//   fetch_state_e      memory-interface FSM states
//   fetch_entry_t      one buffered instruction with its PC
package fetch_stage_pkg;

    localparam int unsigned WORD_WIDTH = 32;
    localparam logic [WORD_WIDTH-1:0] BOOT_ADDR_DEFAULT = 32'h0000_0080;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_WAIT_GNT,
        FETCH_WAIT_RVALID,
        FETCH_WAIT_ABORT
    } fetch_state_e;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] instr;
        logic [WORD_WIDTH-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO buffering fetched instructions.
//   clk, rst_n   clock, asynchronous active-low reset
//   push/data    write one entry (ignored when full)
//   pop          discard head entry (ignored when empty)
//   flush        empty the FIFO; wins over push and pop
//   head         oldest entry
//   count/full/empty  occupancy status
module fetch_fifo #(
    parameter  int unsigned WIDTH = 64,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

    // NOTE: storage is not reset; occupancy is tracked by count, and the consumer masks the head when empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues word reads, buffers returned words, hands
// one instruction + PC per cycle to the decoder, redirects on branch.
//   clk, rst_n                 clock, asynchronous active-low reset
//   fetch_enable_i             allows new memory requests
//   instr_req_o/addr_o         memory request (address held until grant)
//   instr_gnt_i                request accepted
//   instr_rvalid_i/rdata_i     read response
//   branch_i/branch_addr_i     single-cycle redirect
//   instr_valid_o/ready_i      downstream handshake
//   instr_o/pc_o               instruction word and its address
//   illegal_o                  low bits != 2'b11 flag
// Optional feature: define FETCH_ILLEGAL_CHECK_EN to enable illegal_o;
// otherwise illegal_o is tied low.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [WORD_WIDTH-1:0] BOOT_ADDR  = BOOT_ADDR_DEFAULT,
    parameter int unsigned           FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_enable_i,
    output logic                  instr_req_o,
    output logic [WORD_WIDTH-1:0] instr_addr_o,
    input  logic                  instr_gnt_i,
    input  logic                  instr_rvalid_i,
    input  logic [WORD_WIDTH-1:0] instr_rdata_i,
    input  logic                  branch_i,
    input  logic [WORD_WIDTH-1:0] branch_addr_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [WORD_WIDTH-1:0] instr_o,
    output logic [WORD_WIDTH-1:0] pc_o,
    output logic                  illegal_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    // A word arriving this cycle still occupies a slot, so a same-cycle
    // re-request needs count + 1 < FIFO_DEPTH.
    localparam logic [CNT_W-1:0] ROOM_AFTER_PUSH = CNT_W'(FIFO_DEPTH - 1);

    fetch_state_e          state_q, state_d;
    logic [WORD_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [WORD_WIDTH-1:0] req_addr_q, req_addr_d;   // address of the outstanding request
    logic                  abort_pend_q, abort_pend_d; // branch seen while waiting for grant
    logic                  run_q;                      // keeps req low in the first cycle out of reset
    logic                  issue;
    logic                  push;
    logic                  pop;
    fetch_entry_t          push_entry;
    fetch_entry_t          fifo_head;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        req_addr_d   = req_addr_q;
        abort_pend_d = abort_pend_q;
        issue        = 1'b0;
        push         = 1'b0;
        instr_req_o  = 1'b0;
        instr_addr_o = fetch_pc_q;

        unique case (state_q)
            FETCH_IDLE: begin
                issue = run_q && fetch_enable_i && !fifo_full && !branch_i;
            end
            FETCH_WAIT_GNT: begin
                instr_req_o  = 1'b1;
                instr_addr_o = req_addr_q;
                if (instr_gnt_i) begin
                    abort_pend_d = 1'b0;
                    if (abort_pend_q || branch_i) begin
                        state_d = FETCH_WAIT_ABORT;
                    end else begin
                        state_d    = FETCH_WAIT_RVALID;
                        fetch_pc_d = req_addr_q + WORD_WIDTH'(4);
                    end
                end else if (branch_i) begin
                    abort_pend_d = 1'b1;
                end
            end
            FETCH_WAIT_RVALID: begin
                if (instr_rvalid_i) begin
                    state_d = FETCH_IDLE;
                    if (!branch_i) begin
                        push  = 1'b1;
                        issue = fetch_enable_i && (fifo_count < ROOM_AFTER_PUSH);
                    end
                end else if (branch_i) begin
                    state_d = FETCH_WAIT_ABORT;
                end
            end
            FETCH_WAIT_ABORT: begin
                if (instr_rvalid_i) state_d = FETCH_IDLE;
            end
            default: state_d = FETCH_IDLE;
        endcase

        if (issue) begin
            instr_req_o = 1'b1;
            req_addr_d  = fetch_pc_q;
            if (instr_gnt_i) begin
                state_d    = FETCH_WAIT_RVALID;
                fetch_pc_d = fetch_pc_q + WORD_WIDTH'(4);
            end else begin
                state_d = FETCH_WAIT_GNT;
            end
        end

        // The redirect target overrides any sequential increment.
        if (branch_i) fetch_pc_d = {branch_addr_i[WORD_WIDTH-1:2], 2'b00};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH_IDLE;
            fetch_pc_q   <= BOOT_ADDR;
            req_addr_q   <= BOOT_ADDR;
            abort_pend_q <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_addr_q   <= req_addr_d;
            abort_pend_q <= abort_pend_d;
            run_q        <= 1'b1;
        end
    end

    assign push_entry = '{instr: instr_rdata_i, pc: req_addr_q};
    // A branch cycle flushes and does not consume, whatever ready says.
    assign pop        = instr_valid_o && instr_ready_i && !branch_i;

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (branch_i),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign instr_valid_o = !fifo_empty;
    assign instr_o       = fifo_empty ? '0 : fifo_head.instr;
    assign pc_o          = fifo_empty ? '0 : fifo_head.pc;

`ifdef FETCH_ILLEGAL_CHECK_EN
    assign illegal_o = instr_valid_o && (instr_o[1:0] != 2'b11);
`else
    assign illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a memory responder with random
// grant/response delays and a sequence-level model of the instruction stream.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [31:0] BOOT  = 32'h0000_0080;
    localparam int          DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        fetch_enable_i;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        illegal_o;

    fetch_stage #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_enable_i (fetch_enable_i),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .branch_i       (branch_i),
        .branch_addr_i  (branch_addr_i),
        .instr_valid_o  (instr_valid_o),
        .instr_ready_i  (instr_ready_i),
        .instr_o        (instr_o),
        .pc_o           (pc_o),
        .illegal_o      (illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory contents: a hash of the address, except a region of 16-bit-style encodings.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:8] == 24'h000010) return 32'h0000_4501;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Stream model: buffered words form the run starting at exp_pc.
    int          buffered;
    logic [31:0] exp_pc, next_fetch;
    bit          pend, pend_drop, held, held_drop;
    logic [31:0] pend_addr, held_addr;
    int          pend_cnt, gnt_wait;
    int          req_cycles;
    logic [31:0] req_log[$];
    logic [31:0] deliv_log[$];
    // Stimulus controls
    bit          en, rdy, br_go;
    logic [31:0] br_tgt;
    int          gnt_min, gnt_max, rsp_min, rsp_max;

    task automatic model_reset();
        buffered = 0; exp_pc = BOOT; next_fetch = BOOT;
        pend = 0; pend_drop = 0; held = 0; held_drop = 0;
        req_log.delete(); deliv_log.delete();
    endtask

    task automatic step();
        bit          rv, br, gnt, newreq;
        logic [31:0] w, addr;
        logic [1:0]  lo;
        gnt = 0; newreq = 0; addr = '0; lo = 2'b11;
        @(negedge clk);
        rv = pend && (pend_cnt == 0);
        instr_rvalid_i = rv;
        instr_rdata_i  = rv ? mem_word(pend_addr) : $urandom();
        br = br_go; br_go = 0;
        branch_i       = br;
        branch_addr_i  = br ? br_tgt : $urandom();
        fetch_enable_i = en;
        instr_ready_i  = rdy;
        instr_gnt_i    = 1'b0;
        #1;
        check("valid", 32'(instr_valid_o), 32'(buffered > 0));
        if (buffered > 0) begin
            w = mem_word(exp_pc);
            lo = w[1:0];
            check("pc", pc_o, exp_pc);
            check("instr", instr_o, w);
        end
`ifdef FETCH_ILLEGAL_CHECK_EN
        check("illegal", 32'(illegal_o), 32'(buffered > 0 && lo != 2'b11));
`else
        check("illegal", 32'(illegal_o), 32'd0);
`endif
        if (instr_req_o) begin
            req_cycles++;
            addr = instr_addr_o;
            check("addr_align", 32'(addr[1:0]), 32'd0);
            if (held) begin
                check("addr_hold", addr, held_addr);
            end else begin
                newreq = 1;
                check("req_addr", addr, next_fetch);
                check("one_outstanding", 32'(pend && !rv), 32'd0);
                check("room", 32'(buffered + ((pend && !pend_drop) ? 1 : 0) < DEPTH), 32'd1);
                req_log.push_back(addr);
                gnt_wait = $urandom_range(gnt_max, gnt_min);
            end
            gnt = (gnt_wait == 0);
            if (!gnt) gnt_wait--;
            instr_gnt_i = gnt;
        end else if (held) begin
            check("req_held", 32'(instr_req_o), 32'd1);
        end
        @(posedge clk);
        if (buffered > 0 && rdy && !br) begin
            buffered--;
            deliv_log.push_back(exp_pc);
            exp_pc += 32'd4;
        end
        if (rv) begin
            if (!pend_drop && !br) buffered++;
            pend = 0;
        end else if (pend) begin
            pend_cnt--;
        end
        if (gnt) begin
            pend      = 1;
            pend_addr = addr;
            pend_drop = (held && held_drop) || br;
            pend_cnt  = $urandom_range(rsp_max, rsp_min);
            if (!pend_drop) next_fetch = addr + 32'd4;
            held = 0; held_drop = 0;
        end else if (newreq) begin
            held = 1; held_addr = addr; held_drop = 0;
        end
        if (br) begin
            buffered   = 0;
            exp_pc     = br_tgt & ~32'h3;
            next_fetch = br_tgt & ~32'h3;
            if (pend) pend_drop = 1;
            if (held) held_drop = 1;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic set_delays(input int gmin, input int gmax, input int rmin, input int rmax);
        gnt_min = gmin; gnt_max = gmax; rsp_min = rmin; rsp_max = rmax;
    endtask

    // Advance until a granted word is in flight and not returning next cycle.
    task automatic wait_in_flight(input string tag);
        bit ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            ok = pend && !pend_drop && (pend_cnt > 0);
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        int k, rc;
        bit ok;
        rst_n = 0; fetch_enable_i = 1; instr_gnt_i = 0; instr_rvalid_i = 0;
        instr_rdata_i = '0; branch_i = 0; branch_addr_i = '0; instr_ready_i = 1;
        en = 1; rdy = 1; br_go = 0; br_tgt = '0; req_cycles = 0;
        set_delays(0, 0, 0, 0);
        model_reset();

        // Reset state, with fetch enabled
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(instr_req_o), 32'd0);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_illegal", 32'(illegal_o), 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_pc", pc_o, 32'd0);
        @(negedge clk);
        rst_n = 1;

        // Sequential fetch, same-cycle grant, response one cycle later
        run(14);
        check("first_req0", req_log[0], 32'h80);
        check("first_req1", req_log[1], 32'h84);
        check("first_req2", req_log[2], 32'h88);
        check("first_pc0", deliv_log[0], 32'h80);

        // Downstream stalls: buffer fills, requests stop; then drains in order
        rdy = 0;
        run(8);
        rc = req_cycles;
        run(6);
        check("stall_no_req", 32'(req_cycles - rc), 32'd0);
        check("stall_valid", 32'(instr_valid_o), 32'd1);
        rdy = 1;
        k = deliv_log.size();
        run(10);
        check("drain_progress", 32'(deliv_log.size() > k + 3), 32'd1);

        // Branch while a response is outstanding: in-flight word dropped
        set_delays(0, 0, 3, 3);
        wait_in_flight("to_wait_rvalid");
        br_go = 1; br_tgt = 32'h200;
        k = deliv_log.size();
        run(20);
        check("br_rvalid_first_pc", deliv_log[k], 32'h200);

        // Branch while waiting for a delayed grant: old address held, then target
        set_delays(3, 3, 0, 1);
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            ok = held && (gnt_wait > 0);
        end
        check("to_wait_gnt", 32'(ok), 32'd1);
        k = req_log.size();
        br_go = 1; br_tgt = 32'h203;
        run(25);
        check("br_gnt_next_req", req_log[k], 32'h200);

        // PC wrap-around at the top of the address space
        set_delays(0, 0, 0, 0);
        k = deliv_log.size();
        br_go = 1; br_tgt = 32'hFFFF_FFF8;
        run(14);
        check("wrap_pc0", deliv_log[k], 32'hFFFF_FFF8);
        check("wrap_pc2", deliv_log[k + 2], 32'h0);

        // Region of non-32-bit encodings
        br_go = 1; br_tgt = 32'h1000;
        ok = 0;
        step();
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            ok = (buffered > 0);
        end
        check("illegal_region_reached", 32'(ok), 32'd1);
        #2;
`ifdef FETCH_ILLEGAL_CHECK_EN
        check("illegal_4501", 32'(illegal_o), 32'd1);
`else
        check("illegal_4501", 32'(illegal_o), 32'd0);
`endif

        // Random traffic
        set_delays(0, 2, 0, 3);
        k = deliv_log.size();
        for (int i = 0; i < 1500; i++) begin
            en = ($urandom_range(9, 0) != 0);
            rdy = ($urandom_range(3, 0) != 0);
            if ($urandom_range(24, 0) == 0) begin
                br_go = 1;
                br_tgt = ($urandom_range(7, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                                     : $urandom();
            end
            step();
        end
        check("random_progress", 32'(deliv_log.size() > k + 100), 32'd1);

        // Asynchronous reset while a response is outstanding
        en = 1; rdy = 1;
        set_delays(0, 0, 3, 3);
        wait_in_flight("to_wait_rvalid_rst");
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("mid_rst_req", 32'(instr_req_o), 32'd0);
        check("mid_rst_valid", 32'(instr_valid_o), 32'd0);
        check("mid_rst_instr", instr_o, 32'd0);
        check("mid_rst_pc", pc_o, 32'd0);
        check("mid_rst_illegal", 32'(illegal_o), 32'd0);
        @(negedge clk);
        instr_gnt_i = 0; instr_rvalid_i = 0; branch_i = 0;
        rst_n = 1;
        model_reset();
        set_delays(0, 1, 0, 2);
        run(12);
        check("post_rst_req", req_log[0], BOOT);
        check("post_rst_pc", deliv_log[0], BOOT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule
